// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single uart_tx: grants one byte-stream requester at a time
// and sequences start_tx/data_tx against the transmitter's idle_ready_tx.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 16,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           data_tx,
    output logic                 start_tx,
    input  logic                 idle_ready_tx,
    output logic                 busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SEND,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] next_ptr;
    logic             sel_found;
    logic [7:0]       burst_cnt;
    logic [7:0]       to_cnt;
    logic             last_q;
    logic [7:0]       cur_data;
    logic             cur_last;
    logic             own_valid;
    logic             xfer;

    // Walk offsets downward so the smallest offset from ptr is the one that sticks.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        cur_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PTR_W'(i)) begin
                cur_data = req_data[i*8 +: 8];
            end
        end
    end

    assign own_valid = req_valid[owner];
    assign cur_last  = req_last[owner];
    assign xfer      = (state == ST_GRANT) && own_valid && idle_ready_tx;
    assign next_ptr  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == ST_GRANT) begin
            req_ready[owner] = own_valid & idle_ready_tx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            grant     <= '0;
            start_tx  <= 1'b0;
            data_tx   <= 8'h00;
            busy      <= 1'b0;
            burst_cnt <= '0;
            to_cnt    <= '0;
            last_q    <= 1'b0;
        end else begin
            start_tx <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        owner     <= sel_idx;
                        grant     <= NUM_REQ'(1) << sel_idx;
                        burst_cnt <= '0;
                        to_cnt    <= '0;
                        busy      <= 1'b1;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        data_tx   <= cur_data;
                        last_q    <= cur_last;
                        burst_cnt <= burst_cnt + 8'd1;
                        to_cnt    <= '0;
                        start_tx  <= 1'b1;
                        state     <= ST_SEND;
                    end else if (!own_valid) begin
                        if (to_cnt + 8'd1 == 8'(GRANT_TIMEOUT)) begin
                            ptr   <= next_ptr;
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
                end
                ST_SEND: state <= ST_HOLD;
                // idle_ready_tx is ignored here while uart_tx samples the start pulse
                ST_HOLD: state <= ST_WAIT;
                ST_WAIT: begin
                    if (idle_ready_tx) begin
                        if (last_q || burst_cnt == 8'(MAX_BURST)) begin
                            ptr   <= next_ptr;
                            grant <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_GRANT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares a single `uart_tx` transmitter among `NUM_REQ` byte-stream requesters. Each requester offers bytes over a valid/ready handshake with a packet-end marker. The arbiter grants one requester at a time and sequences `start_tx`/`data_tx` against `idle_ready_tx`. It holds the grant until the packet ends, a burst cap is reached, or the requester stalls too long. It sits between client logic and the `uart_tx` inside the UART top level.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `MAX_BURST`, 16: maximum bytes sent per grant before forced release, range 1..255.
- `GRANT_TIMEOUT`, 255: consecutive cycles a granted requester may hold `req_valid` low, in state GRANT, before forced release; range 1..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte from requester i ends its packet.
- `req_ready`  out  NUM_REQ  byte from requester i is accepted this cycle.
- `grant`  out  NUM_REQ  one-hot current owner; all zero when no one owns the transmitter.
- `data_tx`  out  8  byte to `uart_tx`.
- `start_tx`  out  1  one-cycle start pulse to `uart_tx`.
- `idle_ready_tx`  in  1  `uart_tx` is idle and can accept a byte.
- `busy`  out  1  arbiter state is not IDLE.

## Operation
States: IDLE, GRANT, SEND, HOLD, WAIT.

- **IDLE**
  - If any `req_valid` bit is high, select the first set bit searching upward from `ptr`, wrapping at `NUM_REQ`.
  - Register the one-hot `grant`, clear `burst_cnt` and `to_cnt`, then go to GRANT.
  - If no `req_valid` bit is high, stay in IDLE.
- **GRANT** (owner g)
  - `req_ready[g] = req_valid[g] & idle_ready_tx`. This is combinational; all other `req_ready` bits are 0.
  - On transfer:
    - latch `req_data[g]` into `data_tx`;
    - latch `req_last[g]` into `last_q`;
    - increment `burst_cnt`, clear `to_cnt`;
    - go to SEND.
  - If `req_valid[g]` is 0, increment `to_cnt`.
  - When `to_cnt` reaches `GRANT_TIMEOUT`, release.
- **SEND**: `start_tx` = 1 for exactly this cycle, then go to HOLD.
- **HOLD**: one cycle in which `idle_ready_tx` is ignored, to cover `uart_tx` start-sampling latency. Then go to WAIT.
- **WAIT**: stay until `idle_ready_tx` = 1. Then:
  - if `last_q` = 1 or `burst_cnt` = `MAX_BURST`, release;
  - otherwise return to GRANT.
- **Release** (one rule for every exit path)
  - `ptr` = (g+1) mod `NUM_REQ`.
  - `grant` goes to 0 and the state goes to IDLE.
  - IDLE always spends one cycle with `grant` = 0 before the next grant.

Rules:
- Only the current owner is ever ready. Non-owners must hold their `req_valid`/`req_data`/`req_last` stable; the arbiter does not drop their bytes.
- `data_tx` holds its value between loads, including in IDLE.
- `start_tx` is never asserted unless `idle_ready_tx` was 1 in the transfer cycle.
- Changes to a non-owner's `req_valid` while a grant is held have no effect on the current grant.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - state IDLE, `ptr` = 0;
  - `grant` = 0, `req_ready` = 0, `start_tx` = 0, `data_tx` = 8'h00, `busy` = 0;
  - `burst_cnt` = 0, `to_cnt` = 0, `last_q` = 0.
- Cycle-level latency:
  - `req_valid` rises in IDLE at cycle 0.
  - `grant` is valid at cycle 1; `req_ready` can be high at cycle 1.
  - `data_tx`/`start_tx` are valid at cycle 2.
  - HOLD occupies cycle 3; WAIT starts at cycle 4.
- If `idle_ready_tx` is 1 in the WAIT exit cycle N, the next transfer of the same packet can occur at cycle N+1.
- Reset mid-operation: all outputs clear immediately. After `rst` deasserts, no `start_tx` is issued until `idle_ready_tx` = 1 in GRANT. A byte already in flight inside `uart_tx` is not tracked.
- `busy` is a registered decode of state, so it is high from the cycle `grant` is set through the last cycle of WAIT.

## Test plan
- **Single requester:** req 0 sends 3 bytes 0x41, 0x42, 0x43 with `last` on 0x43, and `idle_ready_tx` modelled with a 10-cycle busy. Required: `start_tx` pulses 3 times with `data_tx` 0x41/0x42/0x43, `grant` = 4'b0001 throughout, then 0; `ptr` = 1.
- **Round-robin:** all 4 requesters valid with 1-byte packets (`last` = 1), data 0x10+i, starting at `ptr` = 0. Required: grant order 0,1,2,3,0 and `data_tx` sequence 0x10, 0x11, 0x12, 0x13.
- **Burst cap:** `MAX_BURST` = 2; req 1 offers 5 bytes without `last` while req 2 is valid. Required: 2 bytes from req 1, release, then req 2 is granted before req 1 resumes.
- **Timeout:** `GRANT_TIMEOUT` = 8; req 3 sends 1 byte without `last`, then drops `req_valid`. Required: 8 cycles in GRANT, release with `grant` = 0, `ptr` = 0, and no extra `start_tx`.
- **Transmitter not ready:** `idle_ready_tx` held 0 for 20 cycles at grant. Required: `req_ready` = 0 and `start_tx` = 0 during that time; the transfer occurs in the first cycle `idle_ready_tx` = 1.
- **Reset mid-operation:** assert `rst` = 0 during WAIT. Required: `grant`, `start_tx`, `busy` = 0 and `data_tx` = 0x00 immediately, and IDLE with `ptr` = 0 after release.
